// File: rtl/sar_search_if.sv
// Handshake and comparator bundle for sar_search: the search request, the
// comparator flags and the search results.
interface sar_search_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [WIDTH-1:0] guess;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, gt, eq, lt,
    input  guess, result, busy, done, err
  );

  modport slave (
    input  start, gt, eq, lt,
    output guess, result, busy, done, err
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation binary search, MSB first, driven by an external
// comparator. Define SAR_SEARCH_EARLY_EXIT_EN to finish as soon as eq is seen.
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  sar_search_if.slave bus
);

  localparam int               KW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0]    K_MAX   = KW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIAL = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A valid comparator response has exactly one of gt/eq/lt set.
  function automatic logic is_one_hot3(input logic [2:0] flags);
    return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] guess_r;
  logic [WIDTH-1:0] result_r;
  logic [KW-1:0]    k_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;

  logic             flags_ok_s;
  logic             hit_s;
  logic [KW-1:0]    k_dec_s;
  logic [WIDTH-1:0] kept_s;
  logic [WIDTH-1:0] next_guess_s;

  // Trial decode: decide bit k from the flags and prepare the next trial value.
  always_comb begin
    flags_ok_s   = is_one_hot3({bus.gt, bus.eq, bus.lt});
    k_dec_s      = k_r - KW'(1);
    kept_s       = guess_r;
    if (bus.lt) begin
      kept_s[k_r] = 1'b0;
    end else begin
      kept_s[k_r] = guess_r[k_r];
    end
    // k_dec_s wraps when k_r is zero; next_guess_s is unused on that cycle.
    next_guess_s          = kept_s;
    next_guess_s[k_dec_s] = 1'b1;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
    hit_s = bus.eq;
`else
    hit_s = 1'b0;
`endif
  end

  // Search sequencer with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      guess_r  <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      k_r      <= K_MAX;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r <= TRIAL;
            guess_r <= MSB_ONE;
            k_r     <= K_MAX;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        TRIAL: begin
          if (!flags_ok_s) begin
            result_r <= guess_r;
            err_r    <= 1'b1;
            state_r  <= DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
          end else if (hit_s) begin
            result_r <= guess_r;
            state_r  <= DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
          end else if (k_r == {KW{1'b0}}) begin
            result_r <= kept_s;
            state_r  <= DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
          end else begin
            guess_r <= next_guess_s;
            k_r     <= k_dec_s;
            state_r <= TRIAL;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.guess  = guess_r;
  assign bus.result = result_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.err    = err_r;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search with a behavioural comparator and a
// bisection reference model; honours SAR_SEARCH_EARLY_EXIT_EN.
module tb_sar_search;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] tgt;
  logic         force_bad;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  sar_search_if #(.WIDTH(W)) bus ();

  sar_search #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural comparator: a = target, b = guess; force_bad makes gt and lt both high.
  assign bus.gt = force_bad | (tgt > bus.guess);
  assign bus.eq = ~force_bad & (tgt == bus.guess);
  assign bus.lt = force_bad | (tgt < bus.guess);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Trial i keeps the top i bits of the target and probes the next bit.
  function automatic int model_guess(input int t, input int i);
    int sh;
    sh = W - i;
    return ((t >> sh) << sh) | (1 << (W - 1 - i));
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_val({tag, " guess"},  32'(bus.guess),  32'd0);
    check_val({tag, " result"}, 32'(bus.result), 32'd0);
    check_val({tag, " busy"},   32'(bus.busy),   32'd0);
    check_val({tag, " done"},   32'(bus.done),   32'd0);
    check_val({tag, " err"},    32'(bus.err),    32'd0);
  endtask

  // Runs one search from the current negedge; bad_trial < 0 means clean flags.
  task automatic do_search(input int t, input bit hold, input int bad_trial);
    int nt;
    int exp_res;
    int exp_err;
    nt      = W;
    exp_res = t;
    exp_err = 0;
    for (int i = 0; i < W; i++) begin
      if (i == bad_trial) begin
        nt      = i + 1;
        exp_res = model_guess(t, i);
        exp_err = 1;
        break;
      end
`ifdef SAR_SEARCH_EARLY_EXIT_EN
      if (model_guess(t, i) == t) begin
        nt = i + 1;
        break;
      end
`endif
    end

    tgt       = t[W-1:0];
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;

    for (int i = 0; i < nt; i++) begin
      check_val($sformatf("t%0d busy@%0d", t, i), 32'(bus.busy), 32'd1);
      check_val($sformatf("t%0d guess@%0d", t, i), 32'(bus.guess), 32'(model_guess(t, i)));
      if (i == 0) begin
        check_val($sformatf("t%0d done@0", t), 32'(bus.done), 32'd0);
        check_val($sformatf("t%0d err@0", t), 32'(bus.err), 32'd0);
      end
      if (i == bad_trial) force_bad = 1'b1;
      @(posedge clk);
      @(negedge clk);
      force_bad = 1'b0;
    end

    check_val($sformatf("t%0d done", t),   32'(bus.done),   32'd1);
    check_val($sformatf("t%0d busy", t),   32'(bus.busy),   32'd0);
    check_val($sformatf("t%0d err", t),    32'(bus.err),    32'(exp_err));
    check_val($sformatf("t%0d result", t), 32'(bus.result), 32'(exp_res));
  endtask

  task automatic check_idle_after(input int exp_res);
    @(posedge clk);
    @(negedge clk);
    check_val("idle done",   32'(bus.done),   32'd0);
    check_val("idle busy",   32'(bus.busy),   32'd0);
    check_val("idle result", 32'(bus.result), 32'(exp_res));
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    tgt       = '0;
    force_bad = 1'b0;
    #3;
    check_outputs_zero("reset");

    // Start is raised together with reset release and must be taken immediately.
    @(negedge clk);
    rst_n = 1'b1;
    do_search(11, 1'b0, -1);
    check_idle_after(11);
    do_search(0, 1'b0, -1);
    do_search(15, 1'b0, -1);
    check_idle_after(15);
    do_search(8, 1'b0, -1);
    check_idle_after(8);

    // Invalid flags on the second trial abort with the pre-update guess.
    do_search(11, 1'b0, 1);
    check_idle_after(12);
    check_val("err held", 32'(bus.err), 32'd1);

    // Asynchronous reset in the third trial cycle.
    tgt       = 4'd11;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_val("mid guess@2", 32'(bus.guess), 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_search(6, 1'b0, -1);

    // Start held through the search is ignored, then taken on the DONE cycle.
    do_search(11, 1'b1, -1);
    do_search(5, 1'b0, -1);
    check_idle_after(5);

    for (int n = 0; n < 24; n++) begin
      int t;
      int bad;
      t   = int'($urandom_range(0, 15));
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      do_search(t, 1'b0, bad);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
